// File: rtl/upc_seq_pkg.sv
// Shared opcode encoding and default sizes for the micro-sequencer program counter.
package upc_seq_pkg;

    typedef enum logic [2:0] {
        OP_INC  = 3'd0,
        OP_JMP  = 3'd1,
        OP_BRT  = 3'd2,
        OP_BRF  = 3'd3,
        OP_CALL = 3'd4,
        OP_RET  = 3'd5,
        OP_HOLD = 3'd6,
        OP_RSVD = 3'd7
    } upc_op_e;

    localparam int UPC_AW_DEF = 5;
    localparam int UPC_SD_DEF = 4;

endpackage

// File: rtl/upc_seq_if.sv
// Decoder <-> sequencer connection: opcode/condition/target in, micro-PC and stack status out.
interface upc_seq_if
    import upc_seq_pkg::*;
#(
    parameter int AW = UPC_AW_DEF,
    parameter int DW = $clog2(UPC_SD_DEF + 1)
);
    logic          en;
    upc_op_e       op;
    logic          cond;
    logic [AW-1:0] target;
    logic          err_clr;
    logic [AW-1:0] upc;
    logic [DW-1:0] depth;
    logic          stk_full;
    logic          stk_empty;
    logic          err_ovf;
    logic          err_unf;

    // Decoder side: issues commands, observes the sequencer.
    modport master (
        output en, op, cond, target, err_clr,
        input  upc, depth, stk_full, stk_empty, err_ovf, err_unf
    );

    // Sequencer side.
    modport slave (
        input  en, op, cond, target, err_clr,
        output upc, depth, stk_full, stk_empty, err_ovf, err_unf
    );
endinterface

// File: rtl/upc_stack.sv
// LIFO return-address stack. Only the occupancy pointer is reset; entries are
// written on push and are meaningless until then. dout shows the top entry.
module upc_stack #(
    parameter int W     = 5,
    parameter int DEPTH = 4,
    localparam int DW   = $clog2(DEPTH + 1),
    localparam int IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic [DW-1:0] depth,
    output logic          full,
    output logic          empty
);
    logic [W-1:0]  mem [DEPTH];
    logic [DW-1:0] depth_q;
    logic [DW-1:0] top_idx;

    assign full    = (depth_q == DW'(DEPTH));
    assign empty   = (depth_q == '0);
    assign depth   = depth_q;
    assign top_idx = depth_q - 1'b1;
    assign dout    = empty ? '0 : mem[top_idx[IW-1:0]];

    // Occupancy pointer: push grows, pop shrinks, ignored at the respective limit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            depth_q <= '0;
        end else if (push && !full) begin
            depth_q <= depth_q + 1'b1;
        end else if (pop && !empty) begin
            depth_q <= depth_q - 1'b1;
        end
    end

    // Entry storage: write the new return address into the first free slot.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[depth_q[IW-1:0]] <= din;
        end
    end
endmodule

// File: rtl/upc_seq.sv
// Micro-sequencer program counter: selects the next micro-address from the
// opcode, keeps call return addresses on a LIFO, and latches sticky stack errors.
module upc_seq
    import upc_seq_pkg::*;
#(
    parameter int            AW          = UPC_AW_DEF,
    parameter int            STACK_DEPTH = UPC_SD_DEF,
    parameter logic [AW-1:0] RESET_ADDR  = '0
) (
    input logic       clk,
    input logic       reset,
    upc_seq_if.slave  bus
);
    localparam int DW = $clog2(STACK_DEPTH + 1);

    logic [AW-1:0] upc_q;
    logic [AW-1:0] next_upc;
    logic [AW-1:0] inc_addr;
    logic [AW-1:0] stk_dout;
    logic [DW-1:0] stk_depth;
    logic          stk_full;
    logic          stk_empty;
    logic          push;
    logic          pop;
    logic          set_ovf;
    logic          set_unf;
    logic          err_ovf_q;
    logic          err_unf_q;

    // Natural wrap at 2**AW is intended; no flag on wrap.
    assign inc_addr = upc_q + 1'b1;

    upc_stack #(.W(AW), .DEPTH(STACK_DEPTH)) u_stack (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (inc_addr),
        .dout  (stk_dout),
        .depth (stk_depth),
        .full  (stk_full),
        .empty (stk_empty)
    );

    // Next-address select; a stall holds everything and raises no error.
    always_comb begin
        next_upc = upc_q;
        push     = 1'b0;
        pop      = 1'b0;
        set_ovf  = 1'b0;
        set_unf  = 1'b0;
        if (bus.en) begin
            case (bus.op)
                OP_INC:  next_upc = inc_addr;
                OP_JMP:  next_upc = bus.target;
                OP_BRT:  next_upc = bus.cond ? bus.target : inc_addr;
                OP_BRF:  next_upc = bus.cond ? inc_addr : bus.target;
                OP_CALL: begin
                    if (!stk_full) begin
                        push     = 1'b1;
                        next_upc = bus.target;
                    end else begin
                        next_upc = inc_addr;
                        set_ovf  = 1'b1;
                    end
                end
                OP_RET: begin
                    if (!stk_empty) begin
                        pop      = 1'b1;
                        next_upc = stk_dout;
                    end else begin
                        next_upc = inc_addr;
                        set_unf  = 1'b1;
                    end
                end
                default: next_upc = upc_q;
            endcase
        end
    end

    // Micro-PC register and sticky error flags; a new error wins over a clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            upc_q     <= RESET_ADDR;
            err_ovf_q <= 1'b0;
            err_unf_q <= 1'b0;
        end else begin
            upc_q     <= next_upc;
            err_ovf_q <= set_ovf | (err_ovf_q & ~bus.err_clr);
            err_unf_q <= set_unf | (err_unf_q & ~bus.err_clr);
        end
    end

    assign bus.upc       = upc_q;
    assign bus.depth     = stk_depth;
    assign bus.stk_full  = stk_full;
    assign bus.stk_empty = stk_empty;
    assign bus.err_ovf   = err_ovf_q;
    assign bus.err_unf   = err_unf_q;
endmodule

// File: tb/tb_upc_seq.sv
// Directed bench for upc_seq (AW=5, STACK_DEPTH=4, RESET_ADDR=3).
module tb_upc_seq;
    import upc_seq_pkg::*;

    localparam int AW = 5;
    localparam int SD = 4;
    localparam int DW = $clog2(SD + 1);

    typedef struct {
        logic [AW-1:0] upc;
        logic [DW-1:0] depth;
        logic          ovf;
        logic          unf;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    upc_seq_if #(.AW(AW), .DW(DW)) bus ();

    upc_seq #(.AW(AW), .STACK_DEPTH(SD), .RESET_ADDR(5'd3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic expect_now(input logic [AW-1:0] u, input logic [DW-1:0] d,
                              input logic o, input logic n);
        exp_t e;
        e.upc = u; e.depth = d; e.ovf = o; e.unf = n;
        sb.push_back(e);
    endtask

    task automatic check_out(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s_sb: observed empty scoreboard expected entry", tag);
            return;
        end
        e = sb.pop_front();
        chk({tag, "_upc"},   32'(bus.upc),       32'(e.upc));
        chk({tag, "_depth"}, 32'(bus.depth),     32'(e.depth));
        chk({tag, "_full"},  32'(bus.stk_full),  32'(e.depth == DW'(SD)));
        chk({tag, "_empty"}, 32'(bus.stk_empty), 32'(e.depth == '0));
        chk({tag, "_ovf"},   32'(bus.err_ovf),   32'(e.ovf));
        chk({tag, "_unf"},   32'(bus.err_unf),   32'(e.unf));
    endtask

    task automatic step(input string tag, input logic e, input upc_op_e o, input logic c,
                        input logic [AW-1:0] t, input logic clr,
                        input logic [AW-1:0] eu, input logic [DW-1:0] ed,
                        input logic eo, input logic en_unf);
        bus.en = e; bus.op = o; bus.cond = c; bus.target = t; bus.err_clr = clr;
        expect_now(eu, ed, eo, en_unf);
        @(posedge clk);
        #1;
        check_out(tag);
    endtask

    initial begin
        bus.en = 1'b0; bus.op = OP_HOLD; bus.cond = 1'b0; bus.target = '0; bus.err_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        expect_now(5'd3, 3'd0, 1'b0, 1'b0);
        check_out("por");
        reset = 1'b0;

        // Reset mid-run, with a flag set and a call outstanding.
        step("r_ret_empty", 1, OP_RET,  0, 5'd0,  0, 5'd4,  3'd0, 0, 1);
        step("r_inc",       1, OP_INC,  0, 5'd0,  0, 5'd5,  3'd0, 0, 1);
        step("r_call",      1, OP_CALL, 0, 5'd10, 0, 5'd10, 3'd1, 0, 1);
        reset = 1'b1;
        #1;
        expect_now(5'd3, 3'd0, 1'b0, 1'b0);
        check_out("async_rst");
        @(posedge clk);
        #1;
        reset = 1'b0;
        step("r_inc_after", 1, OP_INC,  0, 5'd0,  0, 5'd4,  3'd0, 0, 0);

        // Wrap and branches.
        step("jmp31",   1, OP_JMP, 0, 5'd31, 0, 5'd31, 3'd0, 0, 0);
        step("wrap",    1, OP_INC, 0, 5'd0,  0, 5'd0,  3'd0, 0, 0);
        step("brt_c0",  1, OP_BRT, 0, 5'd9,  0, 5'd1,  3'd0, 0, 0);
        step("brt_c1",  1, OP_BRT, 1, 5'd9,  0, 5'd9,  3'd0, 0, 0);
        step("brf_c1",  1, OP_BRF, 1, 5'd20, 0, 5'd10, 3'd0, 0, 0);
        step("brf_c0",  1, OP_BRF, 0, 5'd20, 0, 5'd20, 3'd0, 0, 0);

        // Nested calls.
        step("n_jmp2",  1, OP_JMP,  0, 5'd2,  0, 5'd2,  3'd0, 0, 0);
        step("n_call1", 1, OP_CALL, 0, 5'd10, 0, 5'd10, 3'd1, 0, 0);
        step("n_call2", 1, OP_CALL, 0, 5'd20, 0, 5'd20, 3'd2, 0, 0);
        step("n_ret1",  1, OP_RET,  0, 5'd0,  0, 5'd11, 3'd1, 0, 0);
        step("n_ret2",  1, OP_RET,  0, 5'd0,  0, 5'd3,  3'd0, 0, 0);

        // Fill, overflow, unwind, underflow.
        step("o_call1", 1, OP_CALL, 0, 5'd4,  0, 5'd4,  3'd1, 0, 0);
        step("o_call2", 1, OP_CALL, 0, 5'd5,  0, 5'd5,  3'd2, 0, 0);
        step("o_call3", 1, OP_CALL, 0, 5'd6,  0, 5'd6,  3'd3, 0, 0);
        step("o_call4", 1, OP_CALL, 0, 5'd7,  0, 5'd7,  3'd4, 0, 0);
        step("o_call5", 1, OP_CALL, 0, 5'd25, 0, 5'd8,  3'd4, 1, 0);
        step("o_ret1",  1, OP_RET,  0, 5'd0,  0, 5'd7,  3'd3, 1, 0);
        step("o_ret2",  1, OP_RET,  0, 5'd0,  0, 5'd6,  3'd2, 1, 0);
        step("o_ret3",  1, OP_RET,  0, 5'd0,  0, 5'd5,  3'd1, 1, 0);
        step("o_ret4",  1, OP_RET,  0, 5'd0,  0, 5'd4,  3'd0, 1, 0);
        step("o_jmp5",  1, OP_JMP,  0, 5'd5,  0, 5'd5,  3'd0, 1, 0);
        step("o_unf",   1, OP_RET,  0, 5'd0,  0, 5'd6,  3'd0, 1, 1);

        // Stall and error clear.
        step("s_call",     1, OP_CALL, 0, 5'd12, 0, 5'd12, 3'd1, 1, 1);
        step("s_stall_c",  0, OP_CALL, 0, 5'd20, 0, 5'd12, 3'd1, 1, 1);
        step("s_stall_r",  0, OP_RET,  0, 5'd0,  0, 5'd12, 3'd1, 1, 1);
        step("s_clr_en0",  0, OP_INC,  0, 5'd0,  1, 5'd12, 3'd1, 0, 0);
        step("s_ret",      1, OP_RET,  0, 5'd0,  0, 5'd7,  3'd0, 0, 0);
        step("s_unf_clr",  1, OP_RET,  0, 5'd0,  1, 5'd8,  3'd0, 0, 1);
        step("s_clr_en1",  1, OP_INC,  0, 5'd0,  1, 5'd9,  3'd0, 0, 0);

        // HOLD and reserved opcode.
        for (int i = 0; i < 3; i++) step("hold", 1, OP_HOLD, 1, 5'd17, 0, 5'd9, 3'd0, 0, 0);
        for (int i = 0; i < 3; i++) step("rsvd", 1, OP_RSVD, 1, 5'd17, 0, 5'd9, 3'd0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
